// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, frame constants and baud-rate helpers for uart_rx
// Optional feature macro: UART_RX_PARITY_EN
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd5
`endif
  } uart_state_e;

  // Accumulator keeps 8 fractional bits beyond the clock/baud ratio
  function automatic int acc_width(input longint clk_freq, input longint baud);
    return $clog2(clk_freq / baud) + 8;
  endfunction

  function automatic longint acc_increment(input longint clk_freq, input longint baud,
                                           input longint oversample, input int w);
    longint num;
    num = baud * oversample * (longint'(1) << w);
    return (num + clk_freq / 2) / clk_freq;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - phase-accumulator oversample tick generator for uart_rx
// Tick is the carry out of the accumulator; clear restarts the phase at zero.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = acc_width(longint'(CLK_FREQ), longint'(BAUD));
  // One extra bit: the increment may equal 2^W when every clock is a tick
  localparam logic [W:0] INC = (W+1)'(acc_increment(longint'(CLK_FREQ), longint'(BAUD),
                                                    longint'(OVERSAMPLE), W));

  logic [W-1:0] acc;
  logic [W:0]   sum;

  assign sum  = {1'b0, acc} + INC;
  assign tick = sum[W] & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else begin
      acc <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver with majority-vote sampling and one-byte output holding register
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_STOP   = ST_STOP;
  localparam logic [2:0] S_BREAK  = ST_BREAK;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID_LO = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_MID    = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_MID_HI = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);

  logic                 rx_s1, rx_s2, rx_prev;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [1:0]           samp;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 done_q;
  logic                 tick, clear, start_edge;
  logic                 maj, mid_tick, end_tick, keep_byte;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign start_edge = rx_prev & ~rx_s2;
  assign clear      = (state == S_IDLE) & start_edge;
  assign busy       = (state != S_IDLE);

  uart_rx_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  // The third vote is the live sample, so the bit decision lands on the last mid sample
  assign maj      = majority3(samp[1], samp[0], rx_s2);
  assign mid_tick = tick && (cnt == CNT_MID_HI);
  assign end_tick = tick && (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  assign keep_byte = ~par_bad;
`else
  assign keep_byte = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      samp      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      done_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (clear) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
      if (tick && (cnt == CNT_MID_LO || cnt == CNT_MID)) begin
        samp <= {samp[0], rx_s2};
      end

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state <= S_START;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (mid_tick && maj) begin
            state <= S_IDLE;
          end else if (end_tick) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (mid_tick) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
          end
          if (end_tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (mid_tick && ((^shreg) ^ maj)) begin
            parity_err <= 1'b1;
            par_bad    <= 1'b1;
          end
          if (end_tick) begin
            state <= S_STOP;
          end
        end
`endif
        // Leave at mid stop bit so a back-to-back start edge is never missed
        S_STOP: begin
          if (mid_tick) begin
            if (maj) begin
              done_q <= keep_byte;
              state  <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_s2) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized bench for uart_rx at 16 clocks per bit
// Optional feature macro: UART_RX_PARITY_EN enables the parity frame and parity_err checks.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         n_pe = 0;
`endif

  int         total = 0;
  int         bad = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_valid = 0, n_fe = 0, n_ov = 0;
  logic       par_flip = 1'b0;

  uart_rx #(
    .CLK_FREQ  (1843200),
    .BAUD      (115200),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid) n_valid++;
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_pe++;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_v);
    #1 rx = 1'b1;
  endtask

  task automatic wait_got(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_got_timeout", 32'(got_q.size() >= n), 1);
  endtask

  initial begin
    int base, v0, fe0, ov0, fall;
    logic seen;
    logic [7:0] b;

    rst_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);

    // Single clean frame
    base = got_q.size(); v0 = n_valid; fe0 = n_fe; ov0 = n_ov;
    send_frame(8'hA5, 1'b1);
    wait_got(base + 1, 60);
    idle(10);
    @(negedge clk);
    chk("a5_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("a5_data", got_q[base], 8'hA5);
    chk("a5_valid_cycles", n_valid - v0, 1);
    chk("a5_frame_err", n_fe - fe0, 0);
    chk("a5_overrun", n_ov - ov0, 0);
    chk("a5_idle_busy", busy, 0);

    // Short low glitch must be rejected
    base = got_q.size(); v0 = n_valid;
    seen = 1'b0; fall = -1;
    @(posedge clk);
    #1 rx = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      if (c == 5) #1 rx = 1'b1;
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen && fall < 0) fall = c;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_fall_in_time", 32'(fall > 0 && fall - 5 <= 10), 1);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_byte", got_q.size() - base, 0);

    // Bad stop bit, then a good frame
    base = got_q.size(); v0 = n_valid; fe0 = n_fe;
    send_frame(8'h3C, 1'b0);
    idle(20);
    @(negedge clk);
    chk("fe_pulses", n_fe - fe0, 1);
    chk("fe_no_valid", n_valid - v0, 0);
    chk("fe_rx_data_kept", rx_data, 8'hA5);
    send_frame(8'h81, 1'b1);
    wait_got(base + 1, 60);
    idle(5);
    chk("fe_next_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("fe_next_data", got_q[base], 8'h81);
    chk("fe_next_no_err", n_fe - fe0, 1);

    // Back-to-back frames with the consumer stalled
    @(posedge clk);
    #1 rx_ready = 1'b0;
    base = got_q.size(); ov0 = n_ov;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    @(negedge clk);
    chk("ov_pulses", n_ov - ov0, 1);
    chk("ov_rx_data", rx_data, 8'h11);
    chk("ov_rx_valid", rx_valid, 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("ov_drain_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("ov_drain_data", got_q[base], 8'h11);
    chk("ov_valid_cleared", rx_valid, 0);

    // Reset in the middle of data bit 4
    base = got_q.size();
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    #1 rx = b[4];
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 8'h00);
    rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1);
    wait_got(base + 1, 60);
    idle(40);
    chk("midrst_count", got_q.size() - base, 1);
    if (got_q.size() > base) chk("midrst_data_c3", got_q[base], 8'hC3);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit discards the byte
    base = got_q.size(); v0 = n_pe; fe0 = n_fe;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(20);
    chk("par_err_pulses", n_pe - v0, 1);
    chk("par_no_byte", got_q.size() - base, 0);
    chk("par_rx_valid", rx_valid, 0);
    chk("par_no_frame_err", n_fe - fe0, 0);
`endif

    // Random bytes with random idle gaps against an in-order reference stream
    base = got_q.size(); fe0 = n_fe; ov0 = n_ov;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      idle($urandom_range(0, 20));
      send_frame(b, 1'b1);
      exp_q.push_back(b);
    end
    wait_got(base + exp_q.size(), 80);
    idle(10);
    chk("rand_count", got_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < got_q.size()) chk($sformatf("rand_byte%0d", k), got_q[base + k], exp_q[k]);
    end
    chk("rand_no_frame_err", n_fe - fe0, 0);
    chk("rand_no_overrun", n_ov - ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
